// File: rtl/ef_wb_shell_pkg.sv
// Shared definitions for the Wishbone interrupt shell: local register map,
// the error read value and the bus control FSM states.
package ef_wb_shell_pkg;

  localparam logic [7:0]  LOCAL_PAGE = 8'hFF;
  localparam logic [7:0]  OFF_IM     = 8'h00;
  localparam logic [7:0]  OFF_MIS    = 8'h04;
  localparam logic [7:0]  OFF_RIS    = 8'h08;
  localparam logic [7:0]  OFF_ICR    = 8'h0C;
  localparam logic [7:0]  OFF_GCLK   = 8'h10;
  localparam logic [31:0] BAD_DATA   = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LWAIT,
    ST_CWAIT,
    ST_ACK
  } state_t;

endpackage

// File: rtl/ef_wb_irq_ctrl.sv
// Interrupt flag block: per-flag level/edge capture into RIS, IM mask,
// MIS/IRQ generation and write-one-to-clear through ICR.
module ef_wb_irq_ctrl
  import ef_wb_shell_pkg::*;
#(
  parameter int unsigned          NUM_FLAGS = 9,
  parameter logic [NUM_FLAGS-1:0] EDGE_MASK = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_FLAGS-1:0] flags_i,
  input  logic                 im_we,
  input  logic                 icr_we,
  input  logic [31:0]          wdata,
  input  logic [31:0]          wmask,
  input  logic                 to_set,
  output logic [NUM_FLAGS:0]   ris,
  output logic [NUM_FLAGS:0]   im,
  output logic [NUM_FLAGS:0]   mis,
  output logic                 irq
);

  logic [NUM_FLAGS-1:0] flags_q;
  logic [NUM_FLAGS:0]   clr;
  logic                 unused_hi;

  assign clr       = icr_we ? (wdata[NUM_FLAGS:0] & wmask[NUM_FLAGS:0]) : '0;
  assign unused_hi = ^{wdata, wmask};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q <= '0;
      ris     <= '0;
      im      <= '0;
    end else begin
      flags_q <= flags_i;
      if (im_we)
        im <= (im & ~wmask[NUM_FLAGS:0]) | (wdata[NUM_FLAGS:0] & wmask[NUM_FLAGS:0]);
      // Sticky bits: a new event in the same cycle as a clear keeps the bit set.
      for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
        if (EDGE_MASK[i])
          ris[i] <= (flags_i[i] & ~flags_q[i]) | (ris[i] & ~clr[i]);
        else
          ris[i] <= flags_i[i];
      end
      ris[NUM_FLAGS] <= to_set | (ris[NUM_FLAGS] & ~clr[NUM_FLAGS]);
    end
  end

  assign mis = ris & im;
  assign irq = |mis;

endmodule

// File: rtl/ef_wb_irq_shell.sv
// Wishbone classic slave wrapping a core: local interrupt/clock-gate registers
// at page 0xFF, all other addresses forwarded to the core with a timeout.
module ef_wb_irq_shell
  import ef_wb_shell_pkg::*;
#(
  parameter int unsigned          NUM_FLAGS    = 9,
  parameter logic [NUM_FLAGS-1:0] EDGE_MASK    = '0,
  parameter int unsigned          ACK_WAIT     = 0,
  parameter int unsigned          CORE_TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          adr_i,
  input  logic [31:0]          dat_i,
  output logic [31:0]          dat_o,
  input  logic [3:0]           sel_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  output logic                 ack_o,
  output logic                 IRQ,
  input  logic [NUM_FLAGS-1:0] flags_i,
  output logic                 core_stb_o,
  input  logic                 core_ack_i,
  input  logic [31:0]          core_dat_i,
  output logic                 clk_en_o
);

  localparam logic [15:0] LW_LAST = (ACK_WAIT > 0) ? 16'(ACK_WAIT - 1) : 16'd0;
  localparam logic [15:0] CT_LAST = 16'(CORE_TIMEOUT - 1);

  state_t             state, state_n;
  logic [15:0]        cnt, cnt_n;
  logic [31:0]        rdata, dat_n, wmask;
  logic               dat_ld, lwr, to_set, gclk, is_local, req;
  logic [NUM_FLAGS:0] ris, im, mis;
  logic [7:0]         off;
  logic               unused_adr;

  assign off        = adr_i[7:0];
  assign is_local   = (adr_i[15:8] == LOCAL_PAGE);
  assign req        = cyc_i & stb_i;
  assign wmask      = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign unused_adr = ^adr_i[31:16];
  assign clk_en_o   = gclk;

  ef_wb_irq_ctrl #(
    .NUM_FLAGS (NUM_FLAGS),
    .EDGE_MASK (EDGE_MASK)
  ) u_ctrl (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flags_i (flags_i),
    .im_we   (lwr && (off == OFF_IM)),
    .icr_we  (lwr && (off == OFF_ICR)),
    .wdata   (dat_i),
    .wmask   (wmask),
    .to_set  (to_set),
    .ris     (ris),
    .im      (im),
    .mis     (mis),
    .irq     (IRQ)
  );

  always_comb begin
    rdata = BAD_DATA;
    case (off)
      OFF_IM:   rdata = 32'(im);
      OFF_MIS:  rdata = 32'(mis);
      OFF_RIS:  rdata = 32'(ris);
      OFF_ICR:  rdata = '0;
      OFF_GCLK: rdata = {31'b0, gclk};
      default:  ;
    endcase
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dat_ld     = 1'b0;
    dat_n      = rdata;
    lwr        = 1'b0;
    to_set     = 1'b0;
    ack_o      = 1'b0;
    core_stb_o = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          cnt_n = '0;
          if (!is_local) begin
            state_n = ST_CWAIT;
          end else if (ACK_WAIT > 0) begin
            state_n = ST_LWAIT;
          end else begin
            state_n = ST_ACK;
            dat_ld  = 1'b1;
            lwr     = we_i;
          end
        end
      end
      ST_LWAIT: begin
        if (!cyc_i) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == LW_LAST) begin
          state_n = ST_ACK;
          cnt_n   = '0;
          dat_ld  = 1'b1;
          lwr     = we_i;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_CWAIT: begin
        core_stb_o = 1'b1;
        if (!cyc_i) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (core_ack_i) begin
          state_n = ST_ACK;
          cnt_n   = '0;
          dat_ld  = 1'b1;
          dat_n   = core_dat_i;
        end else if (cnt == CT_LAST) begin
          state_n = ST_ACK;
          cnt_n   = '0;
          dat_ld  = 1'b1;
          dat_n   = BAD_DATA;
          to_set  = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_ACK: begin
        ack_o   = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dat_o <= '0;
      gclk  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (dat_ld)
        dat_o <= dat_n;
      if (lwr && (off == OFF_GCLK) && sel_i[0])
        gclk <= dat_i[0];
    end
  end

endmodule

// File: tb/tb_ef_wb_irq_shell.sv
// Bench for ef_wb_irq_shell: a default instance (level flags, no wait) and a
// tuned one (edge flag 0, ACK_WAIT=3, CORE_TIMEOUT=8) sharing one bus driver.
module tb_ef_wb_irq_shell;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0, wdat = '0, core_dat = 32'h0000_1234;
  logic [3:0]  sel = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, core_ack = 1'b0;
  logic [8:0]  flags = '0;
  bit          cur = 1'b0;

  logic [31:0] dat0, dat1, rd;
  logic        ack0, ack1, irq0, irq1, cstb0, cstb1, cen0, cen1;
  logic        ack, cstb;

  always #5 clk = ~clk;

  assign ack  = cur ? ack1  : ack0;
  assign cstb = cur ? cstb1 : cstb0;
  assign rd   = cur ? dat1  : dat0;

  ef_wb_irq_shell #(
    .NUM_FLAGS (9)
  ) dut0 (
    .clk_i (clk), .rst_i (rst), .adr_i (adr), .dat_i (wdat), .dat_o (dat0),
    .sel_i (sel), .cyc_i (cyc & ~cur), .stb_i (stb), .we_i (we), .ack_o (ack0),
    .IRQ (irq0), .flags_i (flags), .core_stb_o (cstb0), .core_ack_i (core_ack),
    .core_dat_i (core_dat), .clk_en_o (cen0)
  );

  ef_wb_irq_shell #(
    .NUM_FLAGS    (9),
    .EDGE_MASK    (9'h001),
    .ACK_WAIT     (3),
    .CORE_TIMEOUT (8)
  ) dut1 (
    .clk_i (clk), .rst_i (rst), .adr_i (adr), .dat_i (wdat), .dat_o (dat1),
    .sel_i (sel), .cyc_i (cyc & cur), .stb_i (stb), .we_i (we), .ack_o (ack1),
    .IRQ (irq1), .flags_i (flags), .core_stb_o (cstb1), .core_ack_i (core_ack),
    .core_dat_i (core_dat), .clk_en_o (cen1)
  );

  typedef struct {
    string       tag;
    logic [31:0] dat;
    bit          chk_dat;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   core_delay = 0;
  int   ccnt = 0;
  int   n_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Core responder: raise core_ack on the core_delay-th strobed cycle (0 = silent).
  always @(negedge clk) begin
    if (cstb) begin
      ccnt++;
      core_ack = (core_delay != 0) && (ccnt == core_delay);
    end else begin
      ccnt     = 0;
      core_ack = 1'b0;
    end
  end

  task automatic xfer(input bit d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [31:0] ed, input bit cd, input int el,
                      input int pulse_at, input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    cur = d; adr = a; wdat = wd; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    e.tag = tag; e.dat = ed; e.chk_dat = cd; e.lat = el;
    sb.push_back(e);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == pulse_at) flags[0] = 1'b1;
      if (ack) begin
        seen = 1'b1;
        e = sb.pop_front();
        check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
        if (e.chk_dat) check({e.tag, "_dat"}, rd, e.dat);
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (pulse_at > 0) flags[0] = 1'b0;
    check({tag, "_acked"}, 32'(seen), 32'd1);
    if (!seen) void'(sb.pop_front());
    @(negedge clk);
    check({tag, "_pulse"}, 32'(ack), 32'd0);
  endtask

  function automatic int llat(input bit d);
    return d ? 4 : 1;
  endfunction

  task automatic rd_chk(input bit d, input logic [15:0] a, input logic [31:0] ed, input string tag);
    xfer(d, 1'b0, {16'h0, a}, '0, 4'hF, ed, 1'b1, llat(d), -1, tag);
  endtask

  task automatic wr(input bit d, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] s,
                    input string tag);
    xfer(d, 1'b1, {16'h0, a}, wd, s, '0, 1'b0, llat(d), -1, tag);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack0",  32'(ack0),  32'd0);
    check("rst_dat0",  dat0,       32'd0);
    check("rst_irq0",  32'(irq0),  32'd0);
    check("rst_cstb1", 32'(cstb1), 32'd0);
    check("rst_cen0",  32'(cen0),  32'd0);
    rst = 1'b0;

    // Level flags on the default instance.
    wr(0, 16'hFF00, 32'h1FF, 4'hF, "im_wr0");
    @(negedge clk) flags[0] = 1'b1;
    @(negedge clk);
    check("lvl_irq_hi", 32'(irq0), 32'd1);
    rd_chk(0, 16'hFF08, 32'h001, "lvl_ris_hi");
    rd_chk(0, 16'hFF04, 32'h001, "lvl_mis_hi");
    wr(0, 16'hFF0C, 32'h1, 4'hF, "lvl_icr");
    rd_chk(0, 16'hFF08, 32'h001, "lvl_ris_icr");
    flags[0] = 1'b0;
    @(negedge clk);
    check("lvl_irq_lo", 32'(irq0), 32'd0);
    rd_chk(0, 16'hFF08, 32'h000, "lvl_ris_lo");

    wr(0, 16'hFF00, 32'hFFFF_FFFF, 4'b0010, "im_byte1");
    rd_chk(0, 16'hFF00, 32'h3FF, "im_rd_sel1");
    wr(0, 16'hFF00, 32'h0, 4'b0001, "im_byte0");
    rd_chk(0, 16'hFF00, 32'h300, "im_rd_sel0");
    rd_chk(0, 16'hFF0C, 32'h0, "icr_rd");
    rd_chk(0, 16'hFF20, 32'hDEADBEEF, "unmapped");
    wr(0, 16'hFF10, 32'h1, 4'hF, "gclk_wr");
    check("clk_en_hi", 32'(cen0), 32'd1);
    rd_chk(0, 16'hFF10, 32'h1, "gclk_rd");

    core_delay = 2;
    xfer(0, 1'b0, 32'h0000_1000, '0, 4'hF, 32'h0000_1234, 1'b1, 3, -1, "core_rd");

    // Edge flag, wait states and timeout on the tuned instance.
    wr(1, 16'hFF00, 32'h3FF, 4'hF, "im_wr1");
    wr(1, 16'hFF0C, 32'h1, 4'hF, "pre_icr");
    rd_chk(1, 16'hFF08, 32'h000, "edge_pre");
    @(negedge clk) flags[0] = 1'b1;
    @(negedge clk) flags[0] = 1'b0;
    @(negedge clk);
    check("edge_irq", 32'(irq1), 32'd1);
    rd_chk(1, 16'hFF08, 32'h001, "edge_sticky");
    wr(1, 16'hFF0C, 32'h1, 4'hF, "edge_icr");
    rd_chk(1, 16'hFF08, 32'h000, "edge_clr");
    xfer(1, 1'b1, 32'h0000_FF0C, 32'h1, 4'hF, '0, 1'b0, 4, 3, "icr_vs_edge");
    rd_chk(1, 16'hFF08, 32'h001, "set_wins");

    core_delay = 0;
    xfer(1, 1'b0, 32'h0000_1000, '0, 4'hF, 32'hDEADBEEF, 1'b1, 9, -1, "core_to");
    rd_chk(1, 16'hFF08, 32'h201, "to_ris");
    rd_chk(1, 16'hFF04, 32'h201, "to_mis");
    check("to_irq", 32'(irq1), 32'd1);

    // Master drops cyc during the wait states: no ack, no write.
    @(negedge clk);
    cur = 1'b1; adr = 32'h0000_FF00; wdat = '0; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack) n_ack++;
      if (i == 1) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
    end
    check("abort_noack", 32'(n_ack), 32'd0);
    rd_chk(1, 16'hFF00, 32'h3FF, "abort_im");

    // Reset while waiting on a silent core.
    @(negedge clk);
    cur = 1'b1; adr = 32'h0000_1000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    check("cwait_stb", 32'(cstb1), 32'd1);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rst2_ack1",  32'(ack1),  32'd0);
    check("rst2_cstb1", 32'(cstb1), 32'd0);
    check("rst2_dat1",  dat1,       32'd0);
    check("rst2_irq1",  32'(irq1),  32'd0);
    check("rst2_cen0",  32'(cen0),  32'd0);
    rst = 1'b0;
    n_ack = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    check("rst2_noack", 32'(n_ack), 32'd0);
    rd_chk(1, 16'hFF08, 32'h000, "rst2_ris");
    rd_chk(1, 16'hFF00, 32'h000, "rst2_im");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ef_wb_irq_shell.md
EF_WB_IRQ_SHELL -- requirements
Module: ef_wb_irq_shell

Interface
REQ-001 SHALL have parameter NUM_FLAGS, default 9: number of core interrupt flags, legal range 1..31.
REQ-002 SHALL have parameter EDGE_MASK [NUM_FLAGS-1:0], default all 0: per flag, 1 = rising-edge sticky, 0 = level.
REQ-003 SHALL have parameter ACK_WAIT, default 0: extra wait cycles on local-register accesses, range 0..7.
REQ-004 SHALL have parameter CORE_TIMEOUT, default 255: cycles to wait for core_ack_i before a timeout, range 1..65535.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i.
REQ-006 clk_i  in  1  system clock; all state updates on its rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 adr_i in 32, dat_i in 32, dat_o out 32, sel_i in 4, cyc_i in 1, stb_i in 1, we_i in 1, ack_o out 1: Wishbone classic slave.
REQ-009 IRQ  out  1  OR of MIS.
REQ-010 flags_i  in  NUM_FLAGS  raw core flags, synchronous to clk_i.
REQ-011 core_stb_o out 1, core_ack_i in 1, core_dat_i in 32: core-side Wishbone (all other signals shared).
REQ-012 clk_en_o  out  1  clock-gate enable for the core (GCLK[0]).

Function
REQ-013 Local space is adr_i[15:8]==8'hFF; all other addresses are core space.
REQ-014 Local map SHALL be: IM 0xFF00 RW, MIS 0xFF04 RO, RIS 0xFF08 RO, ICR 0xFF0C WO (reads 0), GCLK 0xFF10 RW (1 bit).
REQ-015 RIS/IM/MIS width SHALL be NUM_FLAGS+1; bit NUM_FLAGS is TO (core bus timeout, always sticky).
REQ-016 Level flag: RIS[i] = flags_i[i] registered one cycle; ICR has no effect on it.
REQ-017 Edge flag: RIS[i] set when flags_i[i]==1 and its previous sample was 0; cleared by ICR write of 1; set wins over a simultaneous clear.
REQ-018 MIS = RIS & IM; IRQ = |MIS, combinational from registers.
REQ-019 Writes SHALL honour sel_i per byte; unmapped local writes ignored; unmapped local reads return 32'hDEADBEEF.
REQ-020 Control FSM states: IDLE, LWAIT, CWAIT, ACK.
REQ-021 IDLE: cyc_i&stb_i with local address -> LWAIT (ACK_WAIT>0) or ACK; with core address -> CWAIT.
REQ-022 LWAIT counts ACK_WAIT cycles then -> ACK; local write takes effect on the cycle ACK is entered.
REQ-023 CWAIT: core_stb_o=1; core_ack_i=1 -> capture core_dat_i, -> ACK.
REQ-024 CWAIT timeout: after CORE_TIMEOUT cycles without core_ack_i -> ACK with dat_o=32'hDEADBEEF, set RIS TO.
REQ-025 ACK: ack_o=1 for exactly one cycle, dat_o valid, then -> IDLE; minimum local read latency is ack one cycle after request sampled.
REQ-026 cyc_i deasserted in LWAIT or CWAIT -> IDLE next cycle, no ack, no local write, counters cleared.
REQ-027 core_stb_o SHALL be 0 outside CWAIT; core_ack_i outside CWAIT ignored.
REQ-028 Local registers and FSM SHALL run on ungated clk_i.

Reset
REQ-029 On rst_i: FSM=IDLE, ack_o=0, core_stb_o=0, dat_o=0, IM=0, RIS=0, edge history=0, GCLK=0 (clk_en_o=0), counters=0, IRQ=0.
REQ-030 rst_i mid-transaction SHALL abort it with no ack; reset has priority over every other update.

Structure
REQ-031 Shared package ef_wb_shell_pkg SHALL hold register offsets, the 32'hDEADBEEF constant, and the FSM state enum.
REQ-032 Flag logic (edge detect, RIS, IM, MIS, ICR) SHALL be sub-module ef_wb_irq_ctrl; FSM and decode stay in the top.

Verification
REQ-033 Write IM=0x1FF, raise level flag 0 -> RIS[0]=1 next cycle, IRQ=1; drop flag -> RIS[0]=0, IRQ=0.
REQ-034 EDGE_MASK=1, pulse flag 0 one cycle -> RIS[0] stays 1; ICR=0x1 -> RIS[0]=0; ICR write coincident with new edge -> RIS[0]=1.
REQ-035 ACK_WAIT=3, read 0xFF08 -> ack_o exactly 4 cycles after request, single-cycle pulse.
REQ-036 Core read with core_ack_i after 2 cycles, core_dat_i=0x1234 -> dat_o=0x1234 with ack_o one cycle later.
REQ-037 CORE_TIMEOUT=8, core silent -> ack at cycle 9 with 0xDEADBEEF, RIS TO=1; rst_i during CWAIT -> no ack, all outputs at reset values.
